input_skew_feeder: RTL and testbench

//   Input-side counterpart of the grid's output deskew stage. Accepts one

---
 rtl/input_skew_feeder.sv | 139 +++++++++++++
 tb/tb_input_skew_feeder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/input_skew_feeder.sv
// Staircase-skews one N-lane operand vector per beat onto the systolic grid edge, then flushes N-1 zero advances and pulses done.
// Optional downstream backpressure (adds out_ready) is enabled by defining INPUT_SKEW_BACKPRESSURE_EN.
module input_skew_feeder #(
   parameter int N          = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    reset,
`ifdef INPUT_SKEW_BACKPRESSURE_EN
   input  logic                    out_ready,
`endif
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [N*DATA_WIDTH-1:0] in_data,
   input  logic                    in_last,
   output logic [N*DATA_WIDTH-1:0] out_data,
   output logic                    out_valid,
   output logic                    busy,
   output logic                    done
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      FLUSH
   } state_e;

   state_e                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    outValid_q;
   logic                    done_q, done_d;
   logic                    downstreamReady;
   logic                    accept;
   logic                    advance;
   logic [N*DATA_WIDTH-1:0] laneIn;

`ifdef INPUT_SKEW_BACKPRESSURE_EN
   assign downstreamReady = out_ready;
`else
   assign downstreamReady = 1'b1;
`endif

   // Flush advances push zeros so the previous tile never leaks into the next one.
   assign in_ready  = (state_q != FLUSH) & downstreamReady;
   assign accept    = in_valid & in_ready;
   assign advance   = (accept | (state_q == FLUSH)) & downstreamReady;
   assign laneIn    = accept ? in_data : '0;

   assign out_valid = outValid_q;
   assign done      = done_q;
   assign busy      = (state_q != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         outValid_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         outValid_q <= advance;
         done_q     <= done_d;
      end
   end

   // done fires on the advance that moves the last beat's top lane onto out_data.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE, STREAM: begin
            if (accept) begin
               if (in_last) begin
                  if (N == 1) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = FLUSH;
                     cnt_d   = CW'(N - 1);
                  end
               end else begin
                  state_d = STREAM;
               end
            end
         end
         FLUSH: begin
            if (advance) begin
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   for (genvar i = 0; i < N; i++) begin : gLane
      logic [DATA_WIDTH-1:0] outLane_q;

      assign out_data[i*DATA_WIDTH +: DATA_WIDTH] = outLane_q;

      if (i == 0) begin : gDirect
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               outLane_q <= '0;
            end else if (advance) begin
               outLane_q <= laneIn[0 +: DATA_WIDTH];
            end
         end
      end else begin : gDelay
         // Lane i sees i extra advances of delay before its output register.
         logic [DATA_WIDTH-1:0] dly_q [i];

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int j = 0; j < i; j++) begin
                  dly_q[j] <= '0;
               end
               outLane_q <= '0;
            end else if (advance) begin
               dly_q[0] <= laneIn[i*DATA_WIDTH +: DATA_WIDTH];
               for (int j = 1; j < i; j++) begin
                  dly_q[j] <= dly_q[j-1];
               end
               outLane_q <= dly_q[i-1];
            end
         end
      end
   end

endmodule

// File: tb/tb_input_skew_feeder.sv
// Scoreboard bench for input_skew_feeder: a history-of-advances model predicts every output beat.
// Builds with or without INPUT_SKEW_BACKPRESSURE_EN.
module tb_input_skew_feeder;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int W  = N * DW;
`ifdef INPUT_SKEW_BACKPRESSURE_EN
   localparam bit BP = 1'b1;
`else
   localparam bit BP = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         in_last;
   logic [W-1:0] out_data;
   logic         out_valid;
   logic         busy;
   logic         done;
   logic         outReadyDrv;
`ifdef INPUT_SKEW_BACKPRESSURE_EN
   logic         out_ready;
   assign out_ready = outReadyDrv;
`endif

   always #5 clk = ~clk;

   input_skew_feeder #(.N(N), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .reset     (reset),
`ifdef INPUT_SKEW_BACKPRESSURE_EN
      .out_ready (out_ready),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_data  (out_data),
      .out_valid (out_valid),
      .busy      (busy),
      .done      (done)
   );

   typedef struct {
      logic [W-1:0] data;
      logic         done;
   } exp_t;

   exp_t         expQ[$];
   logic [W-1:0] hist[$];
   int           flushRem   = 0;
   bit           inTile     = 1'b0;
   logic [W-1:0] lastOut    = '0;
   int           checkCount = 0;
   int           errorCount = 0;

   task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checkCount++;
      if (act !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Output after an advance: lane i carries lane i of the vector that entered i advances earlier.
   task automatic modelAdvance(input logic [W-1:0] vec, input bit isDone);
      exp_t         e;
      logic [W-1:0] older;
      hist.push_front(vec);
      if (hist.size() > N) void'(hist.pop_back());
      e.data = '0;
      for (int i = 0; i < N; i++) begin
         if (i < hist.size()) begin
            older = hist[i];
            e.data[i*DW +: DW] = older[i*DW +: DW];
         end
      end
      e.done = isDone;
      expQ.push_back(e);
   endtask

   // Called at posedge+1; drives one cycle, checks handshake outputs, predicts the edge.
   task automatic applyStimulus(input bit v, input logic [W-1:0] d, input bit l, input bit r);
      in_valid    = v;
      in_data     = d;
      in_last     = l;
      outReadyDrv = r;
      #1;
      checkOutput("in_ready", W'(in_ready), W'((flushRem == 0) && r));
      checkOutput("busy", W'(busy), W'(inTile || (flushRem > 0)));
      if (r) begin
         if (flushRem > 0) begin
            flushRem--;
            modelAdvance('0, flushRem == 0);
         end else if (v) begin
            if (l) begin
               inTile = 1'b0;
               if (N == 1) begin
                  modelAdvance(d, 1'b1);
               end else begin
                  flushRem = N - 1;
                  modelAdvance(d, 1'b0);
               end
            end else begin
               inTile = 1'b1;
               modelAdvance(d, 1'b0);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int cycles);
      for (int k = 0; k < cycles; k++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
   endtask

   // Asserted at posedge+1, released before the next negedge.
   task automatic doReset();
      reset       = 1'b1;
      in_valid    = 1'b0;
      in_last     = 1'b0;
      in_data     = '0;
      outReadyDrv = 1'b1;
      expQ.delete();
      hist.delete();
      flushRem = 0;
      inTile   = 1'b0;
      lastOut  = '0;
      #1;
      checkOutput("reset out_data", out_data, '0);
      checkOutput("reset out_valid", W'(out_valid), '0);
      checkOutput("reset busy", W'(busy), '0);
      checkOutput("reset in_ready", W'(in_ready), W'(1));
      checkOutput("reset done", W'(done), '0);
      #2;
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] row(input int k);
      logic [W-1:0] v;
      for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(8'h10 * k + i);
      return v;
   endfunction

   always @(negedge clk) begin
      if (!reset) begin
         if (out_valid) begin
            if (expQ.size() == 0) begin
               checkCount++;
               errorCount++;
               $display("[TB] FAIL unexpected out_valid: got data %h expected no beat", out_data);
            end else begin
               exp_t e;
               e = expQ.pop_front();
               checkOutput("out_data", out_data, e.data);
               checkOutput("done", W'(done), W'(e.done));
               lastOut = e.data;
            end
         end else begin
            checkOutput("hold out_data", out_data, lastOut);
            checkOutput("done while idle", W'(done), '0);
         end
      end
   end

   initial begin
      logic [W-1:0] rnd;
      reset       = 1'b1;
      in_valid    = 1'b0;
      in_last     = 1'b0;
      in_data     = '0;
      outReadyDrv = 1'b1;
      @(posedge clk);
      #1;
      doReset();

      $display("[TB] single beat");
      applyStimulus(1'b1, {8'h04, 8'h03, 8'h02, 8'h01}, 1'b1, 1'b1);
      idle(6);

      $display("[TB] four back-to-back beats");
      for (int k = 1; k <= 4; k++) applyStimulus(1'b1, row(k), k == 4, 1'b1);
      idle(6);

      $display("[TB] input gap mid-stream");
      applyStimulus(1'b1, row(5), 1'b0, 1'b1);
      applyStimulus(1'b1, row(6), 1'b0, 1'b1);
      idle(2);
      applyStimulus(1'b1, row(7), 1'b0, 1'b1);
      applyStimulus(1'b1, row(8), 1'b1, 1'b1);
      idle(6);

      $display("[TB] reset during flush");
      applyStimulus(1'b1, row(9), 1'b0, 1'b1);
      applyStimulus(1'b1, row(10), 1'b1, 1'b1);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      doReset();
      applyStimulus(1'b1, {8'hd4, 8'hc3, 8'hb2, 8'ha1}, 1'b1, 1'b1);
      idle(6);

      $display("[TB] beat offered while flush exits");
      applyStimulus(1'b1, row(11), 1'b1, 1'b1);
      for (int k = 0; k < N; k++) applyStimulus(1'b1, row(12), 1'b1, 1'b1);
      idle(6);

      if (BP) begin
         $display("[TB] downstream stall in flush");
         applyStimulus(1'b1, row(13), 1'b1, 1'b1);
         applyStimulus(1'b0, '0, 1'b0, 1'b1);
         for (int k = 0; k < 3; k++) applyStimulus(1'b1, row(14), 1'b0, 1'b0);
         idle(6);
      end

      $display("[TB] random traffic");
      for (int c = 0; c < 600; c++) begin
         rnd = {$urandom, $urandom};
         applyStimulus($urandom_range(0, 9) < 7, rnd, $urandom_range(0, 5) == 0,
                       BP ? ($urandom_range(0, 3) != 0) : 1'b1);
      end
      idle(N + 4);

      checkOutput("drained scoreboard", W'(expQ.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
